draw_bug_sprite: RTL and testbench
==================================

// Module: draw_bug_sprite
// PURPOSE
//  Pixel-pipeline stage after the bug position/rotation controller. Overlays a SIZE x SIZE bug
//  sprite on the VGA timing/RGB stream at (xpos,ypos), one of 4 orientations. Reads texels
//  from an external synchronous ROM and forwards timing signals with matched delay.
// PARAMETERS
//  SIZE       64       sprite edge in pixels (square, power of 2; ROM holds SIZE*SIZE texels)
//  ADDR_W     12       ROM address width = 2*log2(SIZE)
//  KEY_COLOR  12'hF0F  transparent texel value (used only with BUG_TRANSPARENCY_EN)
// PORTS
//  pclk        in   1   pixel clock
//  rst         in   1   reset, asynchronous, active-high
//  hcount_in   in   11  horizontal pixel counter
//  vcount_in   in   11  vertical line counter
//  hsync_in    in   1   horizontal sync
//  vsync_in    in   1   vertical sync
//  hblnk_in    in   1   horizontal blanking
//  vblnk_in    in   1   vertical blanking
//  rgb_in      in   12  background colour {r4,g4,b4}
//  xpos        in   12  sprite left edge from position controller
//  ypos        in   12  sprite top edge from position controller
//  rotation    in   2   0=up, 1=left, 2=down, 3=right
//  rgb_pixel   in   12  ROM data; valid 1 cycle after pixel_addr
//  pixel_addr  out  ADDR_W ROM address {row,col}, registered
//  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  delayed timing
//  rgb_out     out  12  composited colour
// BEHAVIOUR
//  - Reset: all outputs, pipeline regs and latched position/rotation go to 0; asynchronous.
//  - Frame latch: xpos/ypos/rotation captured into internal regs only on a cycle with
//    hcount_in==0 && vcount_in==0; held for the whole frame (no mid-frame tearing).
//    Changes at other times take effect at the next frame start.
//  - Pipeline (latency fixed, independent of data):
//    S1 (+1): u=hcount_in-x_l, v=vcount_in-y_l; in_box = hcount_in>=x_l && hcount_in<x_l+SIZE
//      && vcount_in>=y_l && vcount_in<y_l+SIZE. Compare in 13 bits so x_l+SIZE cannot wrap;
//      a sprite crossing the right/bottom edge is clipped, no wrap to the left/top.
//    S2 (+2): pixel_addr={row,col}, N=SIZE-1: rot0 row=v,col=u; rot1 row=u,col=N-v;
//      rot2 row=N-v,col=N-u; rot3 row=N-u,col=v. Outside box pixel_addr holds 0.
//    S3 (+3): rgb_pixel from ROM.  S4 (+4): output register.
//  - Every *_out equals its *_in delayed exactly 4 pclk; in_box/blank flags travel with it.
//  - rgb_out = (in_box && !hblnk && !vblnk) ? rgb_pixel : rgb_in (delayed-aligned values).
//    During blanking rgb_in passes unchanged.
//  - xpos/ypos beyond visible area (e.g. 4000): in_box never true, stream passes unchanged.
//  - Reset mid-frame: pipeline flushes to 0; first frame after release uses x_l=y_l=0,
//    rotation 0, until next frame-start latch.
// CONFIGURATION
//  BUG_TRANSPARENCY_EN defined: inside box, texel == KEY_COLOR -> rgb_out = rgb_in.
//  Not defined: every in-box texel drawn as-is, including KEY_COLOR; KEY_COLOR unused.
// TESTING
//  1 Reset: rst=1 mid-stream -> all outputs 0 same cycle; release -> outputs track inputs +4.
//  2 Passthrough: xpos=ypos=4000, random rgb_in/timing -> every *_out == *_in delayed 4.
//  3 Placement rot0: xpos=100,ypos=50, ROM texel=addr -> pixel (100,50) gives pixel_addr 0
//    at +2; (163,50) gives addr 63; (164,50) and (99,50) give rgb_in.
//  4 Rotation: xpos=ypos=0, rotation 1/2/3 -> pixel (5,0) addr {5,63}/{63,58}/{58,0}.
//  5 Frame latch: change xpos 100->200 at line 10 -> sprite stays at x=100 until
//    hcount=vcount=0 of next frame, then at x=200.
//  6 Clip+key: xpos=780 -> drawn cols 780..799 only, no wrap; with BUG_TRANSPARENCY_EN,
//    texel 12'hF0F -> rgb_in; without, 12'hF0F output.

Source files
------------

// File: rtl/draw_bug_sprite.sv
// rtl/draw_bug_sprite.sv - bug sprite overlay stage for the VGA pixel stream
// Optional feature macro: BUG_TRANSPARENCY_EN (texels equal to KEY_COLOR show the background).
// Four-stage pipeline: box/offset calc, ROM address, ROM read, composite.
// Timing signals and background colour are delayed by the same four cycles.
module draw_bug_sprite #(
  parameter int          SIZE      = 64,
  parameter int          ADDR_W    = 12,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [1:0]        rotation,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out
);

  // Row/column index width and the largest index within the sprite.
  localparam int            CW = ADDR_W / 2;
  localparam logic [CW-1:0] N  = CW'(SIZE - 1);
  // Packed timing word: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}.
  localparam int            TW = 38;

  logic [11:0]   x_l, y_l;
  logic [1:0]    rot_l;
  logic          frame_start;
  logic [11:0]   x_eff, y_eff;
  logic [1:0]    rot_eff;
  logic [12:0]   h13, v13, x13, y13;
  logic          in_box_c;
  logic [CW-1:0] u_c, v_c;

  logic [TW-1:0] tim_in, tim1, tim2, tim3;
  logic          box1, box2, box3;
  logic [CW-1:0] u1, v1;
  logic [1:0]    rot1;
  logic [CW-1:0] row, col;
  logic          draw;

  // The frame-start pixel itself already uses the newly presented position,
  // so the whole frame is drawn from one consistent set of values.
  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign x_eff       = frame_start ? xpos : x_l;
  assign y_eff       = frame_start ? ypos : y_l;
  assign rot_eff     = frame_start ? rotation : rot_l;

  // Box test in 13 bits so x+SIZE never wraps: sprites clip at the right/bottom.
  assign h13      = {2'b00, hcount_in};
  assign v13      = {2'b00, vcount_in};
  assign x13      = {1'b0, x_eff};
  assign y13      = {1'b0, y_eff};
  assign in_box_c = (h13 >= x13) && (h13 < x13 + 13'(SIZE)) &&
                    (v13 >= y13) && (v13 < y13 + 13'(SIZE));
  // Only the low bits of the offset matter inside the box.
  assign u_c      = hcount_in[CW-1:0] - x_eff[CW-1:0];
  assign v_c      = vcount_in[CW-1:0] - y_eff[CW-1:0];

  assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

  // Capture position and rotation once per frame to avoid mid-frame tearing.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      x_l   <= '0;
      y_l   <= '0;
      rot_l <= '0;
    end else if (frame_start) begin
      x_l   <= xpos;
      y_l   <= ypos;
      rot_l <= rotation;
    end
  end

  // Stage 1: sprite-relative offsets, box flag and delayed timing.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      tim1 <= '0;
      box1 <= 1'b0;
      u1   <= '0;
      v1   <= '0;
      rot1 <= '0;
    end else begin
      tim1 <= tim_in;
      box1 <= in_box_c;
      u1   <= u_c;
      v1   <= v_c;
      rot1 <= rot_eff;
    end
  end

  // Map sprite offsets to ROM row/column for the selected orientation.
  always_comb begin
    row = '0;
    col = '0;
    case (rot1)
      2'd0: begin row = v1;     col = u1;     end
      2'd1: begin row = u1;     col = N - v1; end
      2'd2: begin row = N - v1; col = N - u1; end
      default: begin row = N - u1; col = v1; end
    endcase
  end

  // Stage 2: registered ROM address (parked at 0 outside the sprite).
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      pixel_addr <= '0;
      tim2       <= '0;
      box2       <= 1'b0;
    end else begin
      pixel_addr <= box1 ? {row, col} : '0;
      tim2       <= tim1;
      box2       <= box1;
    end
  end

  // Stage 3: wait for the ROM read; its data is valid during this stage.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      tim3 <= '0;
      box3 <= 1'b0;
    end else begin
      tim3 <= tim2;
      box3 <= box2;
    end
  end

`ifdef BUG_TRANSPARENCY_EN
  assign draw = box3 && !tim3[13] && !tim3[12] && (rgb_pixel != KEY_COLOR);
`else
  assign draw = box3 && !tim3[13] && !tim3[12];
`endif

  // Stage 4: composite sprite over background and register all outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= tim3[37:27];
      vcount_out <= tim3[26:16];
      hsync_out  <= tim3[15];
      vsync_out  <= tim3[14];
      hblnk_out  <= tim3[13];
      vblnk_out  <= tim3[12];
      rgb_out    <= draw ? rgb_pixel : tim3[11:0];
    end
  end

endmodule

// File: tb/tb_draw_bug_sprite.sv
// tb/tb_draw_bug_sprite.sv - self-checking bench for draw_bug_sprite
module tb_draw_bug_sprite;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos, rgb_pixel;
  logic [1:0]  rotation;
  logic [11:0] pixel_addr;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_bug_sprite dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rotation(rotation),
    .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  // Texel ROM: each texel holds its own address, one-cycle read latency.
  always @(posedge pclk) rgb_pixel <= pixel_addr;

  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    pix_t        p;
    logic [11:0] rgb_o;
    bit          chk;
  } oexp_t;

  typedef struct {
    logic [11:0] addr;
    bit          chk;
  } aexp_t;

  typedef struct {
    logic [10:0] h, v;
    logic        hb;
    logic [11:0] x, y;
    logic [1:0]  r;
    bit          chk;
    logic [11:0] ea, er;
  } vec_t;

  oexp_t oq[$];
  aexp_t aq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  logic [11:0] m_x, m_y;
  logic [1:0]  m_r;

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the sprite address for the currently latched frame.
  function automatic logic [11:0] model_addr(input logic [10:0] h, input logic [10:0] v, output bit box);
    int du, dv, u, w, row, col;
    box = (int'(h) >= int'(m_x)) && (int'(h) < int'(m_x) + 64) &&
          (int'(v) >= int'(m_y)) && (int'(v) < int'(m_y) + 64);
    du = int'(h) - int'(m_x);
    dv = int'(v) - int'(m_y);
    u  = du & 63;
    w  = dv & 63;
    case (m_r)
      2'd0: begin row = w;      col = u;      end
      2'd1: begin row = u;      col = 63 - w; end
      2'd2: begin row = 63 - w; col = 63 - u; end
      default: begin row = 63 - u; col = w; end
    endcase
    return box ? 12'(row * 64 + col) : 12'd0;
  endfunction

  // One pixel per negedge: compare what has matured, then drive and predict the next.
  task automatic step(input pix_t p, input logic [11:0] x, input logic [11:0] y, input logic [1:0] r,
                      input bit use_tab, input bit chk, input logic [11:0] t_addr, input logic [11:0] t_rgb);
    aexp_t ae;
    oexp_t oe;
    bit    box;
    logic [11:0] e_addr, e_rgb;
    bit    draw;
    @(negedge pclk);
    if (aq.size() == 2) begin
      ae = aq.pop_front();
      if (ae.chk) check("pixel_addr", 38'(pixel_addr), 38'(ae.addr));
    end
    if (oq.size() == 4) begin
      oe = oq.pop_front();
      check("timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, 12'h000},
            {oe.p.h, oe.p.v, oe.p.hs, oe.p.vs, oe.p.hb, oe.p.vb, 12'h000});
      if (oe.chk) check("rgb_out", 38'(rgb_out), 38'(oe.rgb_o));
    end
    hcount_in = p.h; vcount_in = p.v; hsync_in = p.hs; vsync_in = p.vs;
    hblnk_in = p.hb; vblnk_in = p.vb; rgb_in = p.rgb;
    xpos = x; ypos = y; rotation = r;
    if (p.h == 11'd0 && p.v == 11'd0) begin
      m_x = x; m_y = y; m_r = r;
    end
    e_addr = model_addr(p.h, p.v, box);
    draw   = box && !p.hb && !p.vb;
`ifdef BUG_TRANSPARENCY_EN
    if (e_addr == 12'hF0F) draw = 1'b0;
`endif
    e_rgb = draw ? e_addr : p.rgb;
    if (use_tab) begin
      e_addr = t_addr;
      e_rgb  = t_rgb;
    end
    aq.push_back('{addr: e_addr, chk: chk});
    oq.push_back('{p: p, rgb_o: e_rgb, chk: chk});
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic hb,
                     input logic [11:0] rgb, input logic [11:0] x, input logic [11:0] y, input logic [1:0] r);
    pix_t p;
    p = '{h: h, v: v, hs: h[3], vs: v[2], hb: hb, vb: 1'b0, rgb: rgb};
    step(p, x, y, r, 1'b0, 1'b1, 12'h0, 12'h0);
  endtask

  // Asynchronous reset mid-stream: outputs must clear before any clock edge.
  task automatic mid_reset();
    @(negedge pclk);
    hcount_in = 11'd5; vcount_in = 11'd5;
    #2 rst = 1'b1;
    #1;
    check("reset_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, 38'd0);
    check("reset_addr", 38'(pixel_addr), 38'd0);
    aq.delete();
    oq.delete();
    m_x = '0; m_y = '0; m_r = '0;
    @(negedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  vec_t tab[16];
  pix_t p;

  initial begin
    tab[0]  = '{11'd0,   11'd0,   1'b0, 12'd100, 12'd50, 2'd0, 1'b0, 12'h000, 12'h000};
    tab[1]  = '{11'd100, 11'd50,  1'b0, 12'd100, 12'd50, 2'd0, 1'b1, 12'h000, 12'h000};
    tab[2]  = '{11'd163, 11'd50,  1'b0, 12'd100, 12'd50, 2'd0, 1'b1, 12'h03F, 12'h03F};
    tab[3]  = '{11'd164, 11'd50,  1'b0, 12'd100, 12'd50, 2'd0, 1'b1, 12'h000, 12'h123};
    tab[4]  = '{11'd99,  11'd50,  1'b0, 12'd100, 12'd50, 2'd0, 1'b1, 12'h000, 12'h123};
    tab[5]  = '{11'd100, 11'd113, 1'b0, 12'd100, 12'd50, 2'd0, 1'b1, 12'hFC0, 12'hFC0};
    tab[6]  = '{11'd100, 11'd114, 1'b0, 12'd100, 12'd50, 2'd0, 1'b1, 12'h000, 12'h123};
    tab[7]  = '{11'd110, 11'd52,  1'b0, 12'd100, 12'd50, 2'd0, 1'b1, 12'h08A, 12'h08A};
    tab[8]  = '{11'd110, 11'd52,  1'b1, 12'd100, 12'd50, 2'd0, 1'b1, 12'h08A, 12'h123};
    tab[9]  = '{11'd0,   11'd0,   1'b0, 12'd0,   12'd0,  2'd1, 1'b0, 12'h000, 12'h000};
    tab[10] = '{11'd5,   11'd0,   1'b0, 12'd0,   12'd0,  2'd1, 1'b1, 12'h17F, 12'h17F};
    tab[11] = '{11'd0,   11'd0,   1'b0, 12'd0,   12'd0,  2'd2, 1'b0, 12'h000, 12'h000};
    tab[12] = '{11'd5,   11'd0,   1'b0, 12'd0,   12'd0,  2'd2, 1'b1, 12'hFFA, 12'hFFA};
    tab[13] = '{11'd0,   11'd0,   1'b0, 12'd0,   12'd0,  2'd3, 1'b0, 12'h000, 12'h000};
    tab[14] = '{11'd5,   11'd0,   1'b0, 12'd0,   12'd0,  2'd3, 1'b1, 12'hE80, 12'hE80};
    tab[15] = '{11'd5,   11'd0,   1'b0, 12'd0,   12'd0,  2'd1, 1'b1, 12'hE80, 12'hE80};

    rst = 1'b1;
    hcount_in = 11'd5; vcount_in = 11'd5; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = 12'h000;
    xpos = 0; ypos = 0; rotation = 0;
    m_x = 0; m_y = 0; m_r = 0;
    repeat (3) @(negedge pclk);
    check("init_rgb", 38'(rgb_out), 38'd0);
    check("init_addr", 38'(pixel_addr), 38'd0);
    rst = 1'b0;

    // Placement, rotations, blanking and frame-latch hold from the table.
    for (int i = 0; i < 16; i++) begin
      p = '{h: tab[i].h, v: tab[i].v, hs: 1'b0, vs: 1'b0, hb: tab[i].hb, vb: 1'b0, rgb: 12'h123};
      step(p, tab[i].x, tab[i].y, tab[i].r, 1'b1, tab[i].chk, tab[i].ea, tab[i].er);
    end

    // Off-screen sprite: random stream passes through untouched.
    pix(11'd0, 11'd0, 1'b0, 12'h456, 12'd4000, 12'd4000, 2'd0);
    for (int i = 0; i < 200; i++) begin
      p = '{h: 11'($urandom), v: 11'($urandom), hs: 1'($urandom), vs: 1'($urandom),
            hb: 1'($urandom), vb: 1'($urandom), rgb: 12'($urandom)};
      step(p, 12'd4000, 12'd4000, 2'($urandom), 1'b0, 1'b1, 12'h0, 12'h0);
    end

    // Frame latch: a mid-frame move only applies from the next frame start.
    pix(11'd0,   11'd0,  1'b0, 12'h777, 12'd100, 12'd0, 2'd0);
    pix(11'd100, 11'd10, 1'b0, 12'h777, 12'd200, 12'd0, 2'd0);
    pix(11'd150, 11'd10, 1'b0, 12'h777, 12'd200, 12'd0, 2'd0);
    pix(11'd200, 11'd10, 1'b0, 12'h777, 12'd200, 12'd0, 2'd0);
    pix(11'd0,   11'd0,  1'b0, 12'h777, 12'd200, 12'd0, 2'd0);
    pix(11'd100, 11'd10, 1'b0, 12'h777, 12'd200, 12'd0, 2'd0);
    pix(11'd200, 11'd10, 1'b0, 12'h777, 12'd200, 12'd0, 2'd0);
    pix(11'd263, 11'd10, 1'b0, 12'h777, 12'd200, 12'd0, 2'd0);
    pix(11'd264, 11'd10, 1'b0, 12'h777, 12'd200, 12'd0, 2'd0);

    // Right-edge clip (blanked beyond 799), no wrap, and the key-colour texel at (795,60).
    pix(11'd0, 11'd0, 1'b0, 12'h0A0, 12'd780, 12'd0, 2'd0);
    for (int h = 770; h < 850; h += 5)
      pix(11'(h), 11'd60, 1'(h >= 800), 12'h0A0, 12'd780, 12'd0, 2'd0);
    for (int h = 1; h < 21; h += 4)
      pix(11'(h), 11'd60, 1'b0, 12'h0A0, 12'd780, 12'd0, 2'd0);

    // Random placements and orientations near the sprite.
    for (int f = 0; f < 6; f++) begin
      logic [11:0] x, y;
      logic [1:0]  r;
      x = 12'($urandom_range(0, 700));
      y = 12'($urandom_range(0, 500));
      r = 2'($urandom);
      pix(11'd0, 11'd0, 1'b0, 12'h321, x, y, r);
      for (int i = 0; i < 40; i++)
        pix(11'(int'(x) + $urandom_range(0, 70) - 3), 11'(int'(y) + $urandom_range(0, 70) - 3),
            1'($urandom_range(0, 7) == 0), 12'($urandom), x, y, r);
    end

    // Mid-stream reset; the next frame runs from origin until a new latch.
    pix(11'd0, 11'd0, 1'b0, 12'h111, 12'd300, 12'd300, 2'd2);
    pix(11'd310, 11'd310, 1'b0, 12'h111, 12'd300, 12'd300, 2'd2);
    mid_reset();
    pix(11'd3, 11'd4, 1'b0, 12'h222, 12'd300, 12'd300, 2'd2);
    pix(11'd310, 11'd310, 1'b0, 12'h222, 12'd300, 12'd300, 2'd2);
    pix(11'd63, 11'd63, 1'b0, 12'h222, 12'd300, 12'd300, 2'd2);
    pix(11'd64, 11'd1, 1'b0, 12'h222, 12'd300, 12'd300, 2'd2);
    pix(11'd0, 11'd0, 1'b0, 12'h222, 12'd300, 12'd300, 2'd2);
    pix(11'd310, 11'd310, 1'b0, 12'h222, 12'd300, 12'd300, 2'd2);
    pix(11'd3, 11'd4, 1'b0, 12'h222, 12'd300, 12'd300, 2'd2);

    // Drain the pipeline so every queued expectation is compared.
    repeat (5) pix(11'd1000, 11'd700, 1'b1, 12'h000, 12'd300, 12'd300, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
